// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush and optional skid.
// Define PIPE_SKID_EN for the two-entry skid build; undefined gives one entry.
module pipe_stage_skid #(
  parameter int unsigned           DATA_WIDTH = 70,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  up_valid_i,
  output logic                  up_ready_o,
  input  logic [DATA_WIDTH-1:0] up_data_i,
  output logic                  dn_valid_o,
  input  logic                  dn_ready_i,
  output logic [DATA_WIDTH-1:0] dn_data_o,
  input  logic                  flush_i,
  output logic [1:0]            occ_o
);

  logic                  up_xfer;
  logic                  dn_xfer;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [DATA_WIDTH-1:0] m_data_d;

  assign up_xfer    = up_valid_i & up_ready_o;
  assign dn_xfer    = dn_valid_o & dn_ready_i;
  assign dn_data_o  = m_data_q;

`ifdef PIPE_SKID_EN

  // Bit 0 is M.valid, bit 1 is S.valid; S without M is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [DATA_WIDTH-1:0] s_data_q;
  logic [DATA_WIDTH-1:0] s_data_d;

  assign up_ready_o = ~state_q[1];
  assign dn_valid_o = state_q[0];
  assign occ_o      = {1'b0, state_q[0]} + {1'b0, state_q[1]};

  // Entry FSM: M always holds the older payload, S the younger one.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush_i) begin
      state_d  = ST_EMPTY;
      m_data_d = RST_VAL;
      s_data_d = RST_VAL;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            state_d  = ST_ONE;
            m_data_d = up_data_i;
          end
        end
        ST_ONE: begin
          if (up_xfer && dn_xfer) begin
            m_data_d = up_data_i;
          end else if (up_xfer) begin
            state_d  = ST_TWO;
            s_data_d = up_data_i;
          end else if (dn_xfer) begin
            state_d  = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (dn_xfer) begin
            state_d  = ST_ONE;
            m_data_d = s_data_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      m_data_q <= RST_VAL;
      s_data_q <= RST_VAL;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
    end
  end

`else

  logic m_valid_q;
  logic m_valid_d;

  assign up_ready_o = ~m_valid_q | dn_ready_i;
  assign dn_valid_o = m_valid_q;
  assign occ_o      = {1'b0, m_valid_q};

  // Single entry: load on accept, drop valid when drained.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
      m_data_d  = RST_VAL;
    end else if (up_xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = up_data_i;
    end else if (dn_xfer) begin
      m_valid_d = 1'b0;
    end
  end

  // Valid and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= RST_VAL;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboard checks for pipe_stage_skid.
// Follows PIPE_SKID_EN the same way as the design.
module tb_pipe_stage_skid;

  localparam int unsigned W = 70;
  localparam logic [W-1:0] RV = 70'h5A5;
`ifdef PIPE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         up_valid_i;
  logic         up_ready_o;
  logic [W-1:0] up_data_i;
  logic         dn_valid_o;
  logic         dn_ready_i;
  logic [W-1:0] dn_data_o;
  logic         flush_i;
  logic [1:0]   occ_o;

  int total;
  int bad;

  pipe_stage_skid #(
    .DATA_WIDTH(W),
    .RST_VAL(RV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .up_valid_i(up_valid_i),
    .up_ready_o(up_ready_o),
    .up_data_i(up_data_i),
    .dn_valid_o(dn_valid_o),
    .dn_ready_i(dn_ready_i),
    .dn_data_o(dn_data_o),
    .flush_i(flush_i),
    .occ_o(occ_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d,
                       input logic r, input logic f);
    up_valid_i = v;
    up_data_i  = d;
    dn_ready_i = r;
    flush_i    = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [W-1:0] d, input logic [1:0] o);
    chk({tag, "_vld"}, W'(dn_valid_o), W'(v));
    chk({tag, "_dat"}, dn_data_o, d);
    chk({tag, "_occ"}, W'(occ_o), W'(o));
  endtask

  function automatic logic [W-1:0] rnd();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  logic [W-1:0] q[$];

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), rnd(), 1'($urandom), 1'($urandom));
      tick();
      chk_out("rst", 1'b0, RV, 2'd0);
      chk("rst_rdy", W'(up_ready_o), W'(1));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // streaming
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      chk("str_rdy", W'(up_ready_o), W'(1));
      tick();
      chk_out("str", 1'b1, W'(i), 2'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk_out("str_end", 1'b0, W'(16), 2'd0);

    // backpressure
`ifdef PIPE_SKID_EN
    drive(1'b1, W'('hA), 1'b0, 1'b0);
    tick();
    chk_out("bp1", 1'b1, W'('hA), 2'd1);
    chk("bp1_rdy", W'(up_ready_o), W'(1));
    drive(1'b1, W'('hB), 1'b0, 1'b0);
    tick();
    chk_out("bp2", 1'b1, W'('hA), 2'd2);
    chk("bp2_rdy", W'(up_ready_o), W'(0));
    drive(1'b1, W'('hC), 1'b0, 1'b0);
    tick();
    chk_out("bp3", 1'b1, W'('hA), 2'd2);
    chk("bp3_rdy", W'(up_ready_o), W'(0));
    drive(1'b1, W'('hC), 1'b1, 1'b0);
    tick();
    chk_out("rel1", 1'b1, W'('hB), 2'd1);
    chk("rel1_rdy", W'(up_ready_o), W'(1));
    drive(1'b1, W'('hC), 1'b1, 1'b0);
    tick();
    chk_out("rel2", 1'b1, W'('hC), 2'd1);
`else
    drive(1'b1, W'('hA), 1'b0, 1'b0);
    tick();
    chk_out("bp1", 1'b1, W'('hA), 2'd1);
    chk("bp1_rdy", W'(up_ready_o), W'(0));
    drive(1'b1, W'('hB), 1'b0, 1'b0);
    tick();
    chk_out("bp2", 1'b1, W'('hA), 2'd1);
    drive(1'b1, W'('hB), 1'b0, 1'b0);
    tick();
    chk_out("bp3", 1'b1, W'('hA), 2'd1);
    chk("bp3_rdy", W'(up_ready_o), W'(0));
    drive(1'b1, W'('hB), 1'b1, 1'b0);
    chk("rel_rdy", W'(up_ready_o), W'(1));
    tick();
    chk_out("rel1", 1'b1, W'('hB), 2'd1);
    drive(1'b1, W'('hC), 1'b1, 1'b0);
    tick();
    chk_out("rel2", 1'b1, W'('hC), 2'd1);
`endif
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk_out("rel3", 1'b0, W'('hC), 2'd0);

    // flush with a full stage, upstream offering and downstream ready
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
      tick();
    end
    chk("fl_pre_occ", W'(occ_o), W'(DEPTH));
    drive(1'b1, W'('hD), 1'b1, 1'b1);
    tick();
    chk_out("fl", 1'b0, RV, 2'd0);
    chk("fl_rdy", W'(up_ready_o), W'(1));
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk_out("fl_drop", 1'b0, RV, 2'd0);

    // asynchronous reset mid-cycle with a full stage
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, W'(32'h200 + i), 1'b0, 1'b0);
      tick();
    end
    chk("ar_pre_occ", W'(occ_o), W'(DEPTH));
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar", 1'b0, RV, 2'd0);
    chk("ar_rdy", W'(up_ready_o), W'(1));
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, W'('h77), 1'b0, 1'b0);
    tick();
    chk_out("ar_first", 1'b1, W'('h77), 2'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk_out("ar_drain", 1'b0, W'('h77), 2'd0);

    // random traffic against a FIFO reference
    q.delete();
    for (int c = 0; c < 4000; c++) begin
      logic f, uv, dr, ur, dv, up_x, dn_x;
      logic [W-1:0] ud, dd;
      uv = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      f  = ($urandom_range(0, 40) == 0);
      ud = rnd();
      drive(uv, ud, dr, f);
      ur = up_ready_o;
      dv = dn_valid_o;
      dd = dn_data_o;
      chk("rn_occ", W'(occ_o), W'(q.size()));
      chk("rn_vld", W'(dv), W'(q.size() != 0));
`ifdef PIPE_SKID_EN
      chk("rn_rdy", W'(ur), W'(q.size() < 2));
`else
      chk("rn_rdy", W'(ur), W'((q.size() == 0) || dr));
`endif
      if (q.size() != 0) chk("rn_dat", dd, q[0]);
      up_x = uv & ur;
      dn_x = dv & dr;
      tick();
      if (f) begin
        q.delete();
      end else begin
        if (dn_x && q.size() != 0) void'(q.pop_front());
        if (up_x) q.push_back(ud);
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    tick();
    chk("rn_end_occ", W'(occ_o), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
